// File: rtl/mem_responder_if.sv
// CPU <-> memory port bundle.
// Handshake: the CPU raises memread and/or memwrite with adr/writedata; the
// responder samples them only while idle, then returns a one-cycle ready pulse
// with readdata/err. busy is high while an accepted access is in progress. The
// CPU must drop its request in the ready cycle, or it is taken as a new access.
interface mem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output memread, memwrite, adr, writedata,
    input  readdata, ready, busy, err
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    output readdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: a word array behind a fixed-latency request port.
// A request accepted in IDLE is latched, delayed by WAIT_STATES cycles, then
// performed in a single cycle, after which ready pulses for one cycle.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  output logic [1:0]        dbg_state
);

  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic [31:0] lat_adr;
  logic [31:0] lat_wdata;
  logic        lat_rd;
  logic        lat_wr;
  logic [31:0] readdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic          req;
  logic          accept;
  logic          access;
  logic          addr_ok;
  logic          req_ok;
  logic          mem_we;
  logic [AW-1:0] idx;

  assign req     = bus.memread | bus.memwrite;
  assign idx     = lat_adr[AW+1:2];
  // Alignment and range are judged on the latched address, never the live bus.
  assign addr_ok = (lat_adr[1:0] == 2'b00) &&
                   ({2'b00, lat_adr[31:2]} < 32'(DEPTH));
  assign req_ok  = addr_ok && !(lat_rd && lat_wr);
  // Write commit is gated by state, so an async reset during WAIT (which
  // forces IDLE) can never let a pending write reach the array.
  assign mem_we  = access && lat_wr && req_ok;

  // Next-state and status decode; everything else follows from state.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Request latches, wait counter and completion results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 4'd0;
      lat_adr    <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      readdata_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= WS;
        lat_adr   <= bus.adr;
        lat_wdata <= bus.writedata;
        lat_rd    <= bus.memread;
        lat_wr    <= bus.memwrite;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= !req_ok;
        if (lat_rd) readdata_q <= req_ok ? mem[idx] : 32'd0;
      end
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= lat_wdata;
  end

  assign bus.readdata = readdata_q;
  assign bus.err      = err_q;
  assign bus.ready    = (state == DONE);
  assign bus.busy     = (state == WAIT);
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one DUT with two wait states, one with none.
module tb_mem_responder;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // Shared request drivers, steered to one DUT by sel
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] wd = 32'd0;

  mem_responder_if a_if();
  mem_responder_if b_if();
  logic [1:0] dbg_a, dbg_b;

  assign a_if.memread   = sel ? 1'b0 : rd;
  assign a_if.memwrite  = sel ? 1'b0 : wr;
  assign a_if.adr       = adr;
  assign a_if.writedata = wd;
  assign b_if.memread   = sel ? rd : 1'b0;
  assign b_if.memwrite  = sel ? wr : 1'b0;
  assign b_if.adr       = adr;
  assign b_if.writedata = wd;

  logic        o_ready, o_busy, o_err;
  logic [31:0] o_readdata;
  assign o_ready    = sel ? b_if.ready    : a_if.ready;
  assign o_busy     = sel ? b_if.busy     : a_if.busy;
  assign o_err      = sel ? b_if.err      : a_if.err;
  assign o_readdata = sel ? b_if.readdata : a_if.readdata;

  mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(a_if.slave), .dbg_state(dbg_a)
  );
  mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave), .dbg_state(dbg_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Driver: one complete access from IDLE. lat = edges from acceptance to
  // the edge after which ready is seen (bounded at 20).
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rdat, output logic e,
                        output logic busy_w);
    @(negedge clk);
    rd = r; wr = w; adr = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; adr = 32'hFFFF_FFFF; wd = 32'hFFFF_FFFF;
    busy_w = o_busy;
    lat = 0;
    while (!o_ready && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rdat = o_readdata;
    e    = o_err;
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0 || o_readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b busy=%b err=%b rdata=%h, expected all 0",
               o_ready, o_busy, o_err, o_readdata);
    end
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (o_ready !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b busy=%b, expected 0 0", o_ready, o_busy);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rdat; logic e, bw;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rdat, e, bw);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_tests++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", e); end
    n_tests++;
    if (bw !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", bw); end
    n_tests++;
    if (rdat !== 32'd0) begin n_fail++; $display("FAIL wr_rdata_held: got %h expected 00000000", rdat); end
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, rdat, e, bw);
    n_tests++;
    if (rdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rdat); end
    n_tests++;
    if (lat !== 3 || e !== 1'b0) begin n_fail++; $display("FAIL rd_status: got lat=%0d err=%b expected 3 0", lat, e); end
    @(negedge clk);
    n_tests++;
    if (o_ready !== 1'b0 || o_readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_after: got ready=%b rdata=%h expected 0 deadbeef", o_ready, o_readdata);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rdat; logic e, bw;
    access(1'b1, 1'b0, 32'h13, 32'h0, lat, rdat, e, bw);
    n_tests++;
    if (e !== 1'b1 || rdat !== 32'd0) begin
      n_fail++;
      $display("FAIL misaligned_rd: got err=%b rdata=%h expected 1 00000000", e, rdat);
    end
    access(1'b0, 1'b1, 32'h0, 32'h11111111, lat, rdat, e, bw);
    access(1'b0, 1'b1, 32'h400, 32'h22222222, lat, rdat, e, bw);
    n_tests++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL range_wr_err: got %b expected 1", e); end
    @(negedge clk);
    n_tests++;
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_held: got %b expected 1", o_err); end
    access(1'b1, 1'b0, 32'h0, 32'h0, lat, rdat, e, bw);
    n_tests++;
    if (rdat !== 32'h11111111 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL range_wr_no_commit: got rdata=%h err=%b expected 11111111 0", rdat, e);
    end
  endtask

  task automatic test_both();
    int lat; logic [31:0] rdat; logic e, bw;
    access(1'b0, 1'b1, 32'h20, 32'h5555AAAA, lat, rdat, e, bw);
    access(1'b1, 1'b1, 32'h20, 32'h00001234, lat, rdat, e, bw);
    n_tests++;
    if (e !== 1'b1 || rdat !== 32'd0) begin
      n_fail++;
      $display("FAIL both_req: got err=%b rdata=%h expected 1 00000000", e, rdat);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, lat, rdat, e, bw);
    n_tests++;
    if (rdat !== 32'h5555AAAA) begin n_fail++; $display("FAIL both_no_commit: got %h expected 5555aaaa", rdat); end
  endtask

  task automatic test_ignored();
    int pulses;
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; adr = 32'h10;
    @(posedge clk);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (o_ready) pulses++;
      if (i == 0) rd = 1'b0;
      if (i == 1) rd = 1'b1;
      if (i == 2) rd = 1'b0;
      @(posedge clk);
    end
    n_tests++;
    if (pulses !== 1) begin n_fail++; $display("FAIL toggle_in_wait: got %0d pulses expected 1", pulses); end
    n_tests++;
    if (o_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL toggle_rdata: got %h expected deadbeef", o_readdata); end
  endtask

  task automatic test_back_to_back();
    int cnt, r1, r2;
    logic [31:0] d2;
    cnt = 0; r1 = -1; r2 = -1; d2 = 32'd0;
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; adr = 32'h10;
    @(posedge clk);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (o_ready) begin
        if (cnt == 0) r1 = i;
        else begin r2 = i; d2 = o_readdata; end
        cnt++;
      end
      if (i == 5) rd = 1'b0;
      @(posedge clk);
    end
    n_tests++;
    if (cnt !== 2 || r1 !== 3 || r2 !== 8) begin
      n_fail++;
      $display("FAIL held_request: got pulses=%0d at %0d,%0d expected 2 at 3,8", cnt, r1, r2);
    end
    n_tests++;
    if (d2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL held_rdata: got %h expected deadbeef", d2); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] rdat; logic e, bw;
    // WAIT_STATES=2 unit
    sel = 1'b0;
    access(1'b0, 1'b1, 32'h4, 32'h0BADF00D, lat, rdat, e, bw);
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, rdat, e, bw);
    access(1'b0, 1'b1, 32'h401, 32'h0, lat, rdat, e, bw);
    n_tests++;
    if (e !== 1'b1 || rdat !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pre_abort: got err=%b rdata=%h expected 1 deadbeef", e, rdat);
    end
    @(negedge clk);
    wr = 1'b1; adr = 32'h4; wd = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    rst_a = 1'b0;
    #1;
    n_tests++;
    if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0 || o_readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got ready=%b busy=%b err=%b rdata=%h expected all 0",
               o_ready, o_busy, o_err, o_readdata);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    access(1'b1, 1'b0, 32'h4, 32'h0, lat, rdat, e, bw);
    n_tests++;
    if (rdat !== 32'h0BADF00D || e !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ws2: got rdata=%h err=%b expected 0badf00d 0", rdat, e);
    end
    // WAIT_STATES=0 unit
    sel = 1'b1;
    access(1'b0, 1'b1, 32'h4, 32'h0BADF00D, lat, rdat, e, bw);
    n_tests++;
    if (lat !== 1 || bw !== 1'b1) begin
      n_fail++;
      $display("FAIL ws0_latency: got lat=%0d busy=%b expected 1 1", lat, bw);
    end
    @(negedge clk);
    wr = 1'b1; adr = 32'h4; wd = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    access(1'b1, 1'b0, 32'h4, 32'h0, lat, rdat, e, bw);
    n_tests++;
    if (rdat !== 32'h0BADF00D || e !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL abort_ws0: got rdata=%h err=%b lat=%0d expected 0badf00d 0 1", rdat, e, lat);
    end
    sel = 1'b0;
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_both();
    test_ignored();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
